mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids and bus defaults.
// Also holds the round-robin winner selection used when latching a request.
package riscv_pkg;

   localparam int unsigned AW_DEFAULT = 32;
   localparam int unsigned DW_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } arb_state_e;

   typedef enum logic {
      ID_FETCH = 1'b0,
      ID_DATA  = 1'b1
   } req_id_e;

   // On a tie the requester that was not granted last wins.
   function automatic req_id_e pick_winner(input logic    fetch_req,
                                           input logic    data_req,
                                           input req_id_e last_grant);
      req_id_e w;
      if (fetch_req && data_req) begin
         w = (last_grant == ID_FETCH) ? ID_DATA : ID_FETCH;
      end else if (data_req) begin
         w = ID_DATA;
      end else begin
         w = ID_FETCH;
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory port around the arbiter.
// slave = arbiter side; master = requesters plus memory.
interface mem_arbiter_if
   import riscv_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) ();

   logic              i_req;
   logic [AW-1:0]     i_addr;
   logic              i_ack;
   logic [DW-1:0]     i_rdata;

   logic              d_req;
   logic              d_we;
   logic [AW-1:0]     d_addr;
   logic [DW-1:0]     d_wdata;
   logic [DW/8-1:0]   d_be;
   logic              d_ack;
   logic [DW-1:0]     d_rdata;

   logic              m_req;
   logic              m_we;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata;
   logic [DW/8-1:0]   m_be;
   logic              m_gnt;
   logic              m_rvalid;
   logic [DW-1:0]     m_rdata;

   modport slave (
      input  i_req, i_addr,
      output i_ack, i_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_be,
      output d_ack, d_rdata,
      output m_req, m_we, m_addr, m_wdata, m_be,
      input  m_gnt, m_rvalid, m_rdata
   );

   modport master (
      output i_req, i_addr,
      input  i_ack, i_rdata,
      output d_req, d_we, d_addr, d_wdata, d_be,
      input  d_ack, d_rdata,
      input  m_req, m_we, m_addr, m_wdata, m_be,
      output m_gnt, m_rvalid, m_rdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory port, one transaction
// outstanding, round-robin on ties, with a WAIT timeout that completes with err.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int AW      = AW_DEFAULT,
   parameter int DW      = DW_DEFAULT,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus,
   output logic          err,
   output logic          stall
);

   localparam int BW     = DW / 8;
   localparam int CW_RAW = $clog2(TIMEOUT + 1);
   localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   arb_state_e        r_state;
   arb_state_e        w_next_state;
   req_id_e           r_winner;
   req_id_e           r_last_grant;
   req_id_e           w_pick;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_next;
   logic              w_latch;
   logic              w_timeout;
   logic              w_done_enter;
   logic [DW-1:0]     w_cap_data;

   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   logic [BW-1:0]     r_be;
   logic              r_m_req;
   logic              r_i_ack;
   logic              r_d_ack;
   logic              r_err;
   logic [DW-1:0]     r_i_rdata;
   logic [DW-1:0]     r_d_rdata;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, latch/timeout strobes and the data captured on completion
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_timeout    = 1'b0;
      w_cnt_next   = r_cnt;
      w_cap_data   = '0;
      w_pick       = pick_winner(bus.i_req, bus.d_req, r_last_grant);
      case (r_state)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               w_next_state = ST_REQ;
               w_latch      = 1'b1;
               w_cnt_next   = '0;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.m_gnt && bus.m_rvalid) begin
               w_next_state = ST_DONE;
               w_cap_data   = bus.m_rdata;
            end else if (bus.m_gnt) begin
               w_next_state = ST_WAIT;
               w_cnt_next   = '0;
            end else begin
               w_next_state = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (bus.m_rvalid) begin
               w_next_state = ST_DONE;
               w_cap_data   = bus.m_rdata;
            end else if (r_cnt == CNT_LAST) begin
               // Forced completion: the response is replaced by zero.
               w_next_state = ST_DONE;
               w_timeout    = 1'b1;
               w_cap_data   = '0;
            end else begin
               w_next_state = ST_WAIT;
               w_cnt_next   = r_cnt + CW'(1);
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
      w_done_enter = (w_next_state == ST_DONE) && (r_state != ST_DONE);
   end

   // Latched payload, grant history, timeout counter and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_winner     <= ID_FETCH;
         r_last_grant <= ID_FETCH;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_m_req      <= 1'b0;
         r_i_ack      <= 1'b0;
         r_d_ack      <= 1'b0;
         r_err        <= 1'b0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
      end else begin
         r_cnt <= w_cnt_next;
         if (w_latch) begin
            r_winner     <= w_pick;
            r_last_grant <= w_pick;
            if (w_pick == ID_DATA) begin
               r_we    <= bus.d_we;
               r_addr  <= bus.d_addr;
               r_wdata <= bus.d_wdata;
               r_be    <= bus.d_be;
            end else begin
               r_we    <= 1'b0;
               r_addr  <= bus.i_addr;
               r_wdata <= '0;
               r_be    <= {BW{1'b1}};
            end
         end
         r_m_req <= (w_next_state == ST_REQ);
         r_i_ack <= w_done_enter && (r_winner == ID_FETCH);
         r_d_ack <= w_done_enter && (r_winner == ID_DATA);
         r_err   <= w_timeout;
         if (w_done_enter && (r_winner == ID_FETCH)) begin
            r_i_rdata <= w_cap_data;
         end
         if (w_done_enter && (r_winner == ID_DATA)) begin
            r_d_rdata <= w_cap_data;
         end
      end
   end

   assign bus.m_req   = r_m_req;
   assign bus.m_we    = r_we;
   assign bus.m_addr  = r_addr;
   assign bus.m_wdata = r_wdata;
   assign bus.m_be    = r_be;
   assign bus.i_ack   = r_i_ack;
   assign bus.i_rdata = r_i_rdata;
   assign bus.d_ack   = r_d_ack;
   assign bus.d_rdata = r_d_rdata;
   assign err         = r_err;
   // Stall reflects live requests against this cycle's ack.
   assign stall       = (bus.i_req & ~r_i_ack) | (bus.d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requesters and memory are driven from one initial
// block; request payloads go into per-port scoreboards and are checked on m_* / ack.
module tb_mem_arbiter;

   localparam int TMO = 15;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } pl_t;

   logic clk;
   logic reset;
   logic err;
   logic stall;

   int   n_cmp;
   int   n_err;
   logic m_last;
   pl_t  sb_i[$];
   pl_t  sb_d[$];
   pl_t  nx_i[$];
   pl_t  nx_d[$];

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .err   (err),
      .stall (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pl_t mk(input logic [31:0] a, input logic we,
                              input logic [31:0] wd, input logic [3:0] be);
      pl_t p;
      p.addr = a; p.we = we; p.wdata = wd; p.be = be;
      return p;
   endfunction

   task automatic drive_i(input logic [31:0] a);
      bus.i_req  = 1'b1;
      bus.i_addr = a;
      sb_i.push_back(mk(a, 1'b0, 32'h0, 4'hF));
   endtask

   task automatic drive_d(input pl_t p);
      bus.d_req   = 1'b1;
      bus.d_we    = p.we;
      bus.d_addr  = p.addr;
      bus.d_wdata = p.wdata;
      bus.d_be    = p.be;
      sb_d.push_back(p);
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      bus.i_req    = 1'b0;
      bus.i_addr   = 32'h0;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_addr   = 32'h0;
      bus.d_wdata  = 32'h0;
      bus.d_be     = 4'h0;
      bus.m_gnt    = 1'b0;
      bus.m_rvalid = 1'b0;
      bus.m_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      m_last = 1'b0;
      sb_i.delete();
      sb_d.delete();
      nx_i.delete();
      nx_d.delete();
   endtask

   // Plays memory for one transaction. rv_dly: 0 = rvalid with gnt, n>0 = n cycles
   // after gnt, <0 = never (timeout). Returns cycles waited for m_req and granted id.
   task automatic mem_txn(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          output int wcyc, output logic gid);
      pl_t e;
      wcyc = 0;
      gid  = 1'b0;
      while (bus.m_req !== 1'b1 && wcyc < 40) begin
         @(negedge clk);
         wcyc++;
      end
      chk("m_req_seen", {63'h0, bus.m_req}, 64'h1);
      if (bus.m_req !== 1'b1) return;
      gid    = (bus.i_req && bus.d_req) ? ~m_last : bus.d_req;
      m_last = gid;
      chk("sb_nonempty", {63'h0, (gid ? sb_d.size() : sb_i.size()) != 0}, 64'h1);
      if ((gid ? sb_d.size() : sb_i.size()) == 0) return;
      e = gid ? sb_d.pop_front() : sb_i.pop_front();
      chk("m_addr", {32'h0, bus.m_addr}, {32'h0, e.addr});
      chk("m_we", {63'h0, bus.m_we}, {63'h0, e.we});
      chk("m_be", {60'h0, bus.m_be}, {60'h0, e.be});
      if (e.we) chk("m_wdata", {32'h0, bus.m_wdata}, {32'h0, e.wdata});
      for (int k = 0; k < gnt_dly; k++) begin
         @(negedge clk);
         chk("hold_m_req", {63'h0, bus.m_req}, 64'h1);
         chk("hold_m_addr", {32'h0, bus.m_addr}, {32'h0, e.addr});
         chk("hold_m_wdata", {32'h0, bus.m_wdata}, {32'h0, (e.we ? e.wdata : bus.m_wdata)});
         chk("hold_m_be", {60'h0, bus.m_be}, {60'h0, e.be});
      end
      bus.m_gnt    = 1'b1;
      bus.m_rvalid = (rv_dly == 0);
      bus.m_rdata  = (rv_dly == 0) ? rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      bus.m_gnt    = 1'b0;
      bus.m_rvalid = 1'b0;
      if (rv_dly > 0) begin
         repeat (rv_dly - 1) @(negedge clk);
         bus.m_rvalid = 1'b1;
         bus.m_rdata  = rdata;
         @(negedge clk);
         bus.m_rvalid = 1'b0;
      end else if (rv_dly < 0) begin
         bus.m_rdata = 32'hFFFF_FFFF;
         repeat (TMO - 1) @(negedge clk);
         chk("no_early_ack", {63'h0, bus.i_ack | bus.d_ack}, 64'h0);
         @(negedge clk);
      end
      chk("i_ack", {63'h0, bus.i_ack}, {63'h0, ~gid});
      chk("d_ack", {63'h0, bus.d_ack}, {63'h0, gid});
      chk("err", {63'h0, err}, {63'h0, (rv_dly < 0)});
      chk("rdata", {32'h0, (gid ? bus.d_rdata : bus.i_rdata)},
          {32'h0, ((rv_dly < 0) ? 32'h0 : rdata)});
      chk("stall_at_ack", {63'h0, stall}, {63'h0, (gid ? bus.i_req : bus.d_req)});
      if (gid) begin
         if (nx_d.size() > 0) drive_d(nx_d.pop_front());
         else bus.d_req = 1'b0;
      end else begin
         if (nx_i.size() > 0) drive_i(nx_i.pop_front().addr);
         else bus.i_req = 1'b0;
      end
      @(negedge clk);
      chk("ack_pulse", {62'h0, bus.i_ack, bus.d_ack}, 64'h0);
      chk("err_pulse", {63'h0, err}, 64'h0);
   endtask

   initial begin
      int   w;
      logic g;
      logic [31:0] d_keep;
      n_cmp = 0;
      n_err = 0;
      do_reset();

      // Reset state
      chk("rst_m_req", {63'h0, bus.m_req}, 64'h0);
      chk("rst_acks", {62'h0, bus.i_ack, bus.d_ack}, 64'h0);
      chk("rst_err", {63'h0, err}, 64'h0);
      chk("rst_i_rdata", {32'h0, bus.i_rdata}, 64'h0);
      chk("rst_d_rdata", {32'h0, bus.d_rdata}, 64'h0);
      chk("rst_m_addr", {32'h0, bus.m_addr}, 64'h0);
      chk("rst_stall", {63'h0, stall}, 64'h0);

      // Fetch only, minimum latency: ack in the third cycle counting the req cycle
      drive_i(32'h0000_0010);
      #1 chk("stall_pending", {63'h0, stall}, 64'h1);
      mem_txn(0, 0, 32'h0000_0013, w, g);
      chk("min_latency_wait", w, 64'h1);
      chk("fetch_id", {63'h0, g}, 64'h0);

      // Simultaneous after reset: data first, then fetch
      do_reset();
      drive_i(32'h0000_0200);
      drive_d(mk(32'h0000_0100, 1'b0, 32'h0, 4'hF));
      mem_txn(0, 0, 32'hAAAA_0001, w, g);
      chk("tie_first_data", {63'h0, g}, 64'h1);
      mem_txn(0, 0, 32'h5555_0002, w, g);
      chk("tie_second_fetch", {63'h0, g}, 64'h0);
      chk("d_rdata_held", {32'h0, bus.d_rdata}, 64'hAAAA_0001);

      // Back-to-back from both ports: D,I,D,I,D,I
      nx_i.push_back(mk(32'h2000_0004, 1'b0, 32'h0, 4'hF));
      nx_i.push_back(mk(32'h2000_0008, 1'b0, 32'h0, 4'hF));
      nx_d.push_back(mk(32'h3000_0004, 1'b1, 32'h1111_2222, 4'hC));
      nx_d.push_back(mk(32'h3000_0008, 1'b0, 32'h0, 4'hF));
      drive_i(32'h2000_0000);
      drive_d(mk(32'h3000_0000, 1'b0, 32'h0, 4'hF));
      for (int k = 0; k < 6; k++) begin
         mem_txn(k % 2, k % 3, 32'h1000_0000 + k, w, g);
         chk("grant_order", {63'h0, g}, {63'h0, (k % 2 == 0)});
      end

      // Write with delayed grant; ack one cycle after rvalid
      drive_d(mk(32'h0000_0300, 1'b1, 32'hDEAD_BEEF, 4'b0011));
      mem_txn(2, 1, 32'h0, w, g);
      chk("write_id", {63'h0, g}, 64'h1);

      // Timeout: no rvalid after gnt
      drive_d(mk(32'h0000_0400, 1'b0, 32'h0, 4'hF));
      mem_txn(0, -1, 32'h0, w, g);

      // Reset while in WAIT with a late rvalid
      d_keep = bus.d_rdata;
      drive_i(32'h0000_0500);
      @(negedge clk);
      chk("t6_m_req", {63'h0, bus.m_req}, 64'h1);
      bus.m_gnt = 1'b1;
      @(negedge clk);
      bus.m_gnt = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      reset        = 1'b1;
      bus.i_req    = 1'b0;
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = 32'h0000_0077;
      chk("t6_m_req_low", {63'h0, bus.m_req}, 64'h0);
      @(negedge clk);
      bus.m_rvalid = 1'b0;
      chk("t6_no_ack", {62'h0, bus.i_ack, bus.d_ack}, 64'h0);
      chk("t6_no_err", {63'h0, err}, 64'h0);
      chk("t6_m_req_idle", {63'h0, bus.m_req}, 64'h0);
      chk("t6_i_rdata", {32'h0, bus.i_rdata}, 64'h0);
      chk("t6_d_rdata_rst", {32'h0, bus.d_rdata}, {32'h0, (d_keep & 32'h0)});
      @(negedge clk);
      chk("t6_still_quiet", {61'h0, bus.i_ack, bus.d_ack, bus.m_req}, 64'h0);
      sb_i.delete();
      m_last = 1'b0;

      // Fresh request after the abort proves the FSM is back in IDLE
      drive_i(32'h0000_0600);
      mem_txn(1, 0, 32'h0000_0066, w, g);
      chk("post_rst_wait", w, 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
